// File: rtl/parity_stream.sv
// parity_stream -- streaming packet parity generator.
//
// Folds the parity of a multi-beat packet of WIDTH-bit words into a single
// bit and presents it, together with the beat count and a truncation flag,
// once per packet on a valid/ready result port.
//
// Parameters:
//   WIDTH     data word width in bits (>=1)
//   EVENP     1 = even parity (bit set when the packet's ones count is odd),
//             0 = odd parity  (bit set when the ones count is even),
//             anything else forces out_parity to 0
//   MAX_BEATS beats after which a packet is closed even without in_last
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          beat handshake (in_ready depends on state only)
//   in_data, in_last           beat payload and end-of-packet marker
//   out_valid/out_ready        result handshake
//   out_parity                 packet parity bit
//   out_beats                  beats accepted into the packet (1..MAX_BEATS)
//   out_trunc                  packet closed at MAX_BEATS without in_last
//
// Optional feature (macro PARITY_CHECK_EN):
//   in_chk   expected parity, sampled on the closing beat only
//   out_err  registered with the result: in_chk differs from out_parity
module parity_stream #(
  parameter int  WIDTH     = 8,
  parameter int  EVENP     = 1,
  parameter int  MAX_BEATS = 16,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef PARITY_CHECK_EN
  input  logic             in_chk,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CW-1:0]    out_beats,
  output logic             out_trunc
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_q, par_d;
  logic [CW-1:0] beats_q, beats_d;
  logic          trunc_q, trunc_d;
`ifdef PARITY_CHECK_EN
  logic          err_q, err_d;
`endif

  logic          acc_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          par_nxt;

  // Map the raw running XOR onto the configured parity sense.
  function automatic logic map_par(input logic a);
    if (EVENP == 1)      return a;
    else if (EVENP == 0) return ~a;
    else                 return 1'b0;
  endfunction

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    beats_d  = beats_q;
    trunc_d  = trunc_q;
`ifdef PARITY_CHECK_EN
    err_d    = err_q;
`endif
    acc_nxt  = acc_q ^ (^in_data);
    cnt_nxt  = cnt_q + 1'b1;
    par_nxt  = map_par(acc_nxt);

    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          // Close on the marked last beat, or force-close once the packet
          // reaches MAX_BEATS; the remainder then starts a fresh packet.
          if (in_last || (cnt_nxt == CW'(MAX_BEATS))) begin
            par_d   = par_nxt;
            beats_d = cnt_nxt;
            trunc_d = ~in_last;
`ifdef PARITY_CHECK_EN
            err_d   = in_chk ^ par_nxt;
`endif
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      beats_q <= '0;
      trunc_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      beats_q <= beats_d;
      trunc_q <= trunc_d;
`ifdef PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Handshake flags decode straight from the state register: no path from
  // in_valid or out_ready.
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_parity = par_q;
  assign out_beats  = beats_q;
  assign out_trunc  = trunc_q;
`ifdef PARITY_CHECK_EN
  assign out_err    = err_q;
`endif

endmodule

// File: doc/parity_stream.md
# parity_stream

Streaming parity generator: the parametrised successor to the team's 8-bit combinational parity cell. It folds the parity of a multi-beat packet of WIDTH-bit words into one parity bit, with even or odd sense selected by parameter. It sits between a valid/ready source and sink in the datapath and reports the parity bit, the beat count and a truncation flag once per packet.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- EVENP, 1, parity sense:
  - 1 = even parity: out_parity=1 when the packet's total count of ones is odd
  - 0 = odd parity: out_parity=1 when the count is even
  - any other value: out_parity forced to 0
- MAX_BEATS, 16, maximum beats per packet (≥1); CW = $clog2(MAX_BEATS+1)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  source presents a beat
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  WIDTH  beat data
- in_last  in  1  beat is the final one of its packet
- out_valid  out  1  packet result available
- out_ready  in  1  sink takes the result
- out_parity  out  1  packet parity bit (per EVENP)
- out_beats  out  CW  number of beats accepted into the packet (1..MAX_BEATS)
- out_trunc  out  1  packet was closed at MAX_BEATS without in_last

## Operation
- Two-state FSM: ACCUM (reset state) and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid&&in_ready: acc ^= ^in_data, cnt += 1.
- Packet close: an accepted beat closes the packet when in_last=1, or when cnt+1==MAX_BEATS.
  - On close, result registers load from the post-update acc and cnt.
  - trunc = !in_last. If in_last=1 on the MAX_BEATS-th beat, trunc=0.
  - Then move to HOLD.
- HOLD:
  - in_ready=0, out_valid=1; outputs stay stable until out_ready=1.
  - On out_ready=1, clear acc and cnt and return to ACCUM.
- Parity mapping: out_parity = (EVENP==1) ? acc : (EVENP==0) ? ~acc : 0.
- in_data is ignored when in_valid=0 or in_ready=0. in_last is ignored on beats that are not accepted.
- After a truncated close, the next accepted beat starts a new packet. The source's remaining beats form that new packet.
- Reset (asynchronous assert, any state, including mid-packet or while in HOLD):
  - FSM to ACCUM; acc, cnt and result registers to 0.
  - Outputs: in_ready=1 after reset (0 during reset is not required; it holds 1 whenever state is ACCUM), out_valid=0, out_parity=0, out_beats=0, out_trunc=0.
  - Any partial packet is discarded.

## Timing
- Throughput: one beat per cycle while in ACCUM.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- HOLD lasts at least one cycle. Minimum packet period is (beats + 1) cycles.
- out_ready=1 in the first HOLD cycle completes the transfer in that cycle. in_ready returns to 1 on the next cycle.
- in_ready is a function of state only; it has no combinational path from in_valid or out_ready.
- out_* are registered outputs.

## Configuration
- PARITY_CHECK_EN defined:
  - Adds input in_chk (1 bit), sampled only on the closing beat.
  - Adds output out_err (1 bit), registered alongside the result: out_err = (in_chk != computed out_parity).
  - out_err resets to 0 and is held through HOLD.
  - On a truncated close, in_chk is still sampled from the MAX_BEATS-th beat.
- PARITY_CHECK_EN undefined: neither port exists, and there is no checking logic.

## Test plan
- Reset, EVENP=1, WIDTH=8:
  - After release: in_ready=1, out_valid=0, out_parity=0, out_beats=0, out_trunc=0.
- Single beat 8'hB7 with in_last=1 (6 ones):
  - Next cycle out_valid=1, out_parity=0, out_beats=1, out_trunc=0.
  - With EVENP=0, out_parity=1.
- Three beats 8'h01, 8'h03, 8'h80 (last on 3rd), out_ready held 0 for 4 cycles:
  - out_parity=0, out_beats=3.
  - Outputs stable through HOLD and in_ready=0.
  - Transfer completes on out_ready=1.
- MAX_BEATS=4, five beats of 8'h01 with last on 5th:
  - First result: out_beats=4, out_parity=0, out_trunc=1.
  - Second result: out_beats=1, out_parity=1, out_trunc=0.
- rst_n pulsed low after 2 beats of a packet:
  - out_valid stays 0.
  - Next packet 8'hFF with last gives out_parity=0, out_beats=1, unaffected by the discarded beats.
- PARITY_CHECK_EN, beats 8'h07 then 8'h00 with last and in_chk=0:
  - out_parity=1, out_err=1.
  - Repeat with in_chk=1: out_err=0.
